// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared types and collision rule for the RF write-back sequencer
package rf_wb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic {
        IDLE    = 1'b0,
        PI_PEND = 1'b1
    } state_t;

    typedef enum logic {
        RR_LSU = 1'b0,
        RR_ALU = 1'b1
    } rr_t;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
        logic                 en;
    } rf_wr_t;

    // With a hardwired x0, writes to address 0 are discarded and so never conflict.
    function automatic logic collide(input logic [RF_ADDR_W-1:0] a,
                                     input logic [RF_ADDR_W-1:0] b,
                                     input logic                 r0_hw);
        return (a == b) && (!r0_hw || (a != '0));
    endfunction

endpackage

// File: rtl/rf_wb_sequencer_if.sv
// rtl/rf_wb_sequencer_if.sv - ALU/LSU write requests in, two RF write ports out
interface rf_wb_sequencer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  alu_valid_i;
    logic                  alu_ready_o;
    logic [ADDR_WIDTH-1:0] alu_waddr_i;
    logic [DATA_WIDTH-1:0] alu_wdata_i;

    logic                  lsu_valid_i;
    logic                  lsu_ready_o;
    logic [ADDR_WIDTH-1:0] lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;
    logic                  lsu_pi_en_i;
    logic [ADDR_WIDTH-1:0] lsu_pi_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_pi_wdata_i;

    logic [ADDR_WIDTH-1:0] waddr_a_o;
    logic [DATA_WIDTH-1:0] wdata_a_o;
    logic                  we_a_o;
    logic [ADDR_WIDTH-1:0] waddr_b_o;
    logic [DATA_WIDTH-1:0] wdata_b_o;
    logic                  we_b_o;
    logic                  busy_o;

    modport slave (
        input  alu_valid_i, alu_waddr_i, alu_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  lsu_pi_en_i, lsu_pi_waddr_i, lsu_pi_wdata_i,
        output alu_ready_o, lsu_ready_o,
        output waddr_a_o, wdata_a_o, we_a_o,
        output waddr_b_o, wdata_b_o, we_b_o,
        output busy_o
    );

    modport master (
        output alu_valid_i, alu_waddr_i, alu_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output lsu_pi_en_i, lsu_pi_waddr_i, lsu_pi_wdata_i,
        input  alu_ready_o, lsu_ready_o,
        input  waddr_a_o, wdata_a_o, we_a_o,
        input  waddr_b_o, wdata_b_o, we_b_o,
        input  busy_o
    );
endinterface

// File: rtl/rf_wb_sequencer.sv
// rtl/rf_wb_sequencer.sv - merges ALU and LSU write-backs onto RF write ports A and B
module rf_wb_sequencer
    import rf_wb_pkg::*;
#(
    parameter int ADDR_WIDTH   = RF_ADDR_W,
    parameter int DATA_WIDTH   = RF_DATA_W,
    parameter bit R0_HARDWIRED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    rf_wb_sequencer_if.slave  bus
);

    state_t r_state, w_state_nxt;
    rr_t    r_rr, w_rr_nxt;
    rf_wr_t r_pend, w_pend_nxt;
    rf_wr_t r_port_a, r_port_b;
    rf_wr_t w_a, w_b;
    rf_wr_t w_alu_wr, w_ld_wr, w_pi_wr;

    logic                  w_alu_rdy, w_lsu_rdy;
    logic                  w_pi_eff, w_coll, w_pend_coll;
    logic                  w_we_a, w_we_b;
    logic [ADDR_WIDTH-1:0] w_alu_addr, w_ld_addr, w_pi_addr;
    logic [DATA_WIDTH-1:0] w_alu_data, w_ld_data, w_pi_data;

    assign w_alu_addr = bus.alu_waddr_i;
    assign w_alu_data = bus.alu_wdata_i;
    assign w_ld_addr  = bus.lsu_waddr_i;
    assign w_ld_data  = bus.lsu_wdata_i;
    assign w_pi_addr  = bus.lsu_pi_waddr_i;
    assign w_pi_data  = bus.lsu_pi_wdata_i;

    // A post-increment onto the load's own destination is dropped so the loaded value wins.
    assign w_pi_eff    = bus.lsu_pi_en_i && (w_pi_addr != w_ld_addr);
    assign w_coll      = collide(w_alu_addr, w_ld_addr, R0_HARDWIRED) ||
                         (w_pi_eff && collide(w_alu_addr, w_pi_addr, R0_HARDWIRED));
    assign w_pend_coll = collide(w_alu_addr, r_pend.addr, R0_HARDWIRED);

    assign w_alu_wr = '{addr: w_alu_addr, data: w_alu_data, en: 1'b1};
    assign w_ld_wr  = '{addr: w_ld_addr,  data: w_ld_data,  en: 1'b1};
    assign w_pi_wr  = '{addr: w_pi_addr,  data: w_pi_data,  en: w_pi_eff};

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_pend_nxt  = r_pend;
        w_a         = '0;
        w_b         = '0;
        w_alu_rdy   = 1'b0;
        w_lsu_rdy   = 1'b0;
        case (r_state)
            IDLE: begin
                w_alu_rdy = 1'b1;
                w_lsu_rdy = 1'b1;
                if (bus.alu_valid_i && bus.lsu_valid_i) begin
                    if (w_coll) begin
                        if (r_rr == RR_LSU) begin
                            w_alu_rdy = 1'b0;
                            w_a       = w_ld_wr;
                            w_b       = w_pi_wr;
                            w_rr_nxt  = RR_ALU;
                        end else begin
                            w_lsu_rdy = 1'b0;
                            w_a       = w_alu_wr;
                            w_rr_nxt  = RR_LSU;
                        end
                    end else if (!w_pi_eff) begin
                        w_a = w_ld_wr;
                        w_b = w_alu_wr;
                    end else if (r_rr == RR_LSU) begin
                        w_alu_rdy = 1'b0;
                        w_a       = w_ld_wr;
                        w_b       = w_pi_wr;
                        w_rr_nxt  = RR_ALU;
                    end else begin
                        // Three writes: the post-increment is parked for the next cycle.
                        w_a         = w_ld_wr;
                        w_b         = w_alu_wr;
                        w_pend_nxt  = w_pi_wr;
                        w_state_nxt = PI_PEND;
                        w_rr_nxt    = RR_LSU;
                    end
                end else if (bus.alu_valid_i) begin
                    w_a = w_alu_wr;
                end else if (bus.lsu_valid_i) begin
                    w_a = w_ld_wr;
                    w_b = w_pi_wr;
                end
            end
            PI_PEND: begin
                w_state_nxt = IDLE;
                w_b         = r_pend;
                w_pend_nxt  = '0;
                w_alu_rdy   = !w_pend_coll;
                if (bus.alu_valid_i && !w_pend_coll) begin
                    w_a = w_alu_wr;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_we_a = w_a.en && !(R0_HARDWIRED && (w_a.addr == '0));
    assign w_we_b = w_b.en && !(R0_HARDWIRED && (w_b.addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr     <= RR_LSU;
            r_pend   <= '0;
            r_port_a <= '0;
            r_port_b <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr        <= w_rr_nxt;
            r_pend      <= w_pend_nxt;
            r_port_a.en <= w_we_a;
            r_port_b.en <= w_we_b;
            if (w_we_a) begin
                r_port_a.addr <= w_a.addr;
                r_port_a.data <= w_a.data;
            end
            if (w_we_b) begin
                r_port_b.addr <= w_b.addr;
                r_port_b.data <= w_b.data;
            end
        end
    end

    assign bus.alu_ready_o = w_alu_rdy && !rst;
    assign bus.lsu_ready_o = w_lsu_rdy && !rst;
    assign bus.busy_o      = (r_state == PI_PEND);
    assign bus.waddr_a_o   = r_port_a.addr;
    assign bus.wdata_a_o   = r_port_a.data;
    assign bus.we_a_o      = r_port_a.en;
    assign bus.waddr_b_o   = r_port_b.addr;
    assign bus.wdata_b_o   = r_port_b.data;
    assign bus.we_b_o      = r_port_b.en;

endmodule

// File: tb/tb_rf_wb_sequencer.sv
// tb/tb_rf_wb_sequencer.sv - directed vector bench for rf_wb_sequencer
module tb_rf_wb_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wb_sequencer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    rf_wb_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .R0_HARDWIRED(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (bus.we_a_o) rf[bus.waddr_a_o] <= bus.wdata_a_o;
        if (bus.we_b_o) rf[bus.waddr_b_o] <= bus.wdata_b_o;
    end

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        pe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        e_ar;
        logic        e_lr;
        logic        e_busy;
        logic        e_wa;
        logic [4:0]  e_aa;
        logic [31:0] e_ad;
        logic        e_wb;
        logic [4:0]  e_ba;
        logic [31:0] e_bd;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vt [20];

    function automatic vec_t mk(
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic pe, input logic [4:0] pa, input logic [31:0] pd,
        input logic e_ar, input logic e_lr, input logic e_busy,
        input logic e_wa, input logic [4:0] e_aa, input logic [31:0] e_ad,
        input logic e_wb, input logic [4:0] e_ba, input logic [31:0] e_bd);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.lv = lv; v.la = la; v.ld = ld;
        v.pe = pe; v.pa = pa; v.pd = pd;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_busy = e_busy;
        v.e_wa = e_wa; v.e_aa = e_aa; v.e_ad = e_ad;
        v.e_wb = e_wb; v.e_ba = e_ba; v.e_bd = e_bd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.alu_valid_i    = v.av;
        bus.alu_waddr_i    = v.aa;
        bus.alu_wdata_i    = v.ad;
        bus.lsu_valid_i    = v.lv;
        bus.lsu_waddr_i    = v.la;
        bus.lsu_wdata_i    = v.ld;
        bus.lsu_pi_en_i    = v.pe;
        bus.lsu_pi_waddr_i = v.pa;
        bus.lsu_pi_wdata_i = v.pd;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk($sformatf("v%0d alu_ready", idx), 32'(bus.alu_ready_o), 32'(v.e_ar));
        chk($sformatf("v%0d lsu_ready", idx), 32'(bus.lsu_ready_o), 32'(v.e_lr));
        chk($sformatf("v%0d busy", idx), 32'(bus.busy_o), 32'(v.e_busy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d we_a", idx), 32'(bus.we_a_o), 32'(v.e_wa));
        chk($sformatf("v%0d we_b", idx), 32'(bus.we_b_o), 32'(v.e_wb));
        if (v.e_wa) begin
            chk($sformatf("v%0d waddr_a", idx), 32'(bus.waddr_a_o), 32'(v.e_aa));
            chk($sformatf("v%0d wdata_a", idx), bus.wdata_a_o, v.e_ad);
        end
        if (v.e_wb) begin
            chk($sformatf("v%0d waddr_b", idx), 32'(bus.waddr_b_o), 32'(v.e_ba));
            chk($sformatf("v%0d wdata_b", idx), bus.wdata_b_o, v.e_bd);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t idle_v, coll_v;

    initial begin
        //        av aa     ad            lv la     ld         pe pa     pd         ar lr by wa aa     ad            wb ba     bd
        vt[0]  = mk(1, 5'd3,  32'hA5A5_0001, 0, 5'd0,  32'h0,     0, 5'd0,  32'h0,     1, 1, 0, 1, 5'd3,  32'hA5A5_0001, 0, 5'd0,  32'h0);
        vt[1]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,     0, 5'd0,  32'h0,     1, 1, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0);
        vt[2]  = mk(0, 5'd0,  32'h0,         1, 5'd5,  32'h11,    1, 5'd6,  32'h1004,  1, 1, 0, 1, 5'd5,  32'h11,        1, 5'd6,  32'h1004);
        vt[3]  = mk(1, 5'd7,  32'h77,        1, 5'd5,  32'h55,    1, 5'd6,  32'h66,    0, 1, 0, 1, 5'd5,  32'h55,        1, 5'd6,  32'h66);
        vt[4]  = mk(1, 5'd7,  32'h77,        1, 5'd5,  32'h5A,    1, 5'd6,  32'h6A,    1, 1, 0, 1, 5'd5,  32'h5A,        1, 5'd7,  32'h77);
        vt[5]  = mk(1, 5'd6,  32'h99,        0, 5'd0,  32'h0,     0, 5'd0,  32'h0,     0, 0, 1, 0, 5'd0,  32'h0,         1, 5'd6,  32'h6A);
        vt[6]  = mk(1, 5'd6,  32'h99,        0, 5'd0,  32'h0,     0, 5'd0,  32'h0,     1, 1, 0, 1, 5'd6,  32'h99,        0, 5'd0,  32'h0);
        vt[7]  = mk(1, 5'd9,  32'hA9,        1, 5'd9,  32'h19,    0, 5'd0,  32'h0,     0, 1, 0, 1, 5'd9,  32'h19,        0, 5'd0,  32'h0);
        vt[8]  = mk(1, 5'd9,  32'hA9,        0, 5'd0,  32'h0,     0, 5'd0,  32'h0,     1, 1, 0, 1, 5'd9,  32'hA9,        0, 5'd0,  32'h0);
        vt[9]  = mk(0, 5'd0,  32'h0,         0, 5'd0,  32'h0,     0, 5'd0,  32'h0,     1, 1, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0);
        vt[10] = mk(1, 5'd10, 32'hAA,        1, 5'd10, 32'hBB,    1, 5'd11, 32'hCC,    1, 0, 0, 1, 5'd10, 32'hAA,        0, 5'd0,  32'h0);
        vt[11] = mk(0, 5'd0,  32'h0,         1, 5'd10, 32'hBB,    1, 5'd11, 32'hCC,    1, 1, 0, 1, 5'd10, 32'hBB,        1, 5'd11, 32'hCC);
        vt[12] = mk(0, 5'd0,  32'h0,         1, 5'd4,  32'h44,    1, 5'd4,  32'h48,    1, 1, 0, 1, 5'd4,  32'h44,        0, 5'd0,  32'h0);
        vt[13] = mk(1, 5'd0,  32'hDEAD,      0, 5'd0,  32'h0,     0, 5'd0,  32'h0,     1, 1, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0);
        vt[14] = mk(0, 5'd0,  32'h0,         1, 5'd0,  32'h1,     0, 5'd0,  32'h0,     1, 1, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0);
        vt[15] = mk(1, 5'd12, 32'hC,         1, 5'd13, 32'hD,     0, 5'd0,  32'h0,     1, 1, 0, 1, 5'd13, 32'hD,         1, 5'd12, 32'hC);
        vt[16] = mk(1, 5'd14, 32'hE0,        1, 5'd15, 32'hF0,    1, 5'd14, 32'hE4,    0, 1, 0, 1, 5'd15, 32'hF0,        1, 5'd14, 32'hE4);
        vt[17] = mk(1, 5'd14, 32'hE0,        0, 5'd0,  32'h0,     0, 5'd0,  32'h0,     1, 1, 0, 1, 5'd14, 32'hE0,        0, 5'd0,  32'h0);
        vt[18] = mk(1, 5'd0,  32'h1234,      1, 5'd0,  32'h5678,  0, 5'd0,  32'h0,     1, 1, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0);
        vt[19] = mk(1, 5'd20, 32'h20,        1, 5'd21, 32'h21,    1, 5'd22, 32'h22,    1, 1, 0, 1, 5'd21, 32'h21,        1, 5'd20, 32'h20);

        idle_v = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        coll_v = mk(1, 5'd25, 32'h250, 1, 5'd25, 32'h251, 0, 5'd0, 32'h0, 0, 1, 0, 1, 5'd25, 32'h251, 0, 5'd0, 32'h0);

        drive(idle_v);
        repeat (2) @(posedge clk);
        #1;
        chk("rst alu_ready", 32'(bus.alu_ready_o), 32'd0);
        chk("rst lsu_ready", 32'(bus.lsu_ready_o), 32'd0);
        chk("rst busy", 32'(bus.busy_o), 32'd0);
        chk("rst we_a", 32'(bus.we_a_o), 32'd0);
        chk("rst we_b", 32'(bus.we_b_o), 32'd0);
        chk("rst waddr_a", 32'(bus.waddr_a_o), 32'd0);
        chk("rst wdata_b", bus.wdata_b_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            apply(i, vt[i]);
            if (i == 1) chk("rf x3 after 2 cycles", rf[3], 32'hA5A5_0001);
        end

        chk("rf x9 final", rf[9], 32'hA9);
        chk("rf x6 final", rf[6], 32'h99);
        chk("rf x4 final", rf[4], 32'h44);
        chk("rf x14 final", rf[14], 32'hE0);
        chk("rf x10 final", rf[10], 32'hBB);

        // vt[19] left the sequencer in PI_PEND; reset lands in the middle of it
        @(negedge clk);
        drive(idle_v);
        #1;
        chk("pend busy", 32'(bus.busy_o), 32'd1);
        chk("pend lsu_ready", 32'(bus.lsu_ready_o), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(bus.busy_o), 32'd0);
        chk("midrst alu_ready", 32'(bus.alu_ready_o), 32'd0);
        chk("midrst we_a", 32'(bus.we_a_o), 32'd0);
        chk("midrst we_b", 32'(bus.we_b_o), 32'd0);
        chk("midrst waddr_b", 32'(bus.waddr_b_o), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst edge we_b", 32'(bus.we_b_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst we_a", 32'(bus.we_a_o), 32'd0);
        chk("postrst we_b", 32'(bus.we_b_o), 32'd0);
        chk("postrst busy", 32'(bus.busy_o), 32'd0);
        chk("rf x22 unwritten pend", 32'(rf[22] === 32'h22), 32'd0);

        // LSU wins a collision, leaving rr at ALU; after reset the LSU must win again
        apply(100, coll_v);
        drive(idle_v);
        pulse_reset();
        apply(101, coll_v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
